// File: rtl/io_read_port_buffer.sv
// Per-port read buffer: valid/ready producer side, head-word + full-bit Datapath read side.
// Optional feature macro: IO_READ_BUFFER_UNDERFLOW_COUNT_EN adds an 8-bit saturating underflow_count output.
module io_read_port_buffer #(
  parameter int WORD_WIDTH = 36,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  io_rden,
  output logic [WORD_WIDTH-1:0] io_read_data,
  output logic                  io_read_EF,
`ifdef IO_READ_BUFFER_UNDERFLOW_COUNT_EN
  output logic [7:0]            underflow_count,
`endif
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  push;
  logic                  pop;

  // Status outputs come from the registered count only, so no input reaches an output combinationally.
  assign in_ready     = (count != FULL_COUNT);
  assign io_read_EF   = (count != '0);
  assign fill_level   = count;
  assign io_read_data = (count != '0) ? mem[rd_ptr] : '0;

  assign push = in_valid & in_ready;
  assign pop  = io_rden & io_read_EF;

  // Storage is not cleared on reset; an empty count already masks stale entries.
  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef IO_READ_BUFFER_UNDERFLOW_COUNT_EN
  // Counts read requests made while nothing was available, sticking at the top value.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      underflow_count <= '0;
    end else if (io_rden && !io_read_EF && (underflow_count != 8'hFF)) begin
      underflow_count <= underflow_count + 8'd1;
    end
  end
`endif

endmodule
